dma_master_engine: RTL
======================

// Module: dma_master_engine
// PURPOSE
//  Data-mover half of the DMA. Consumes DMASRC/DMADST/DMALEN/DMAEN from the DMA config-register slave.
//  Copies DMALEN 32-bit words from DMASRC to DMADST over its own AXI4 master port: INCR read burst into a
//  local buffer, then INCR write burst out of it, repeated until done. Raises DMA_interrupt on completion.
// PARAMETERS
//  MAX_BURST  16  max beats per burst = buffer depth in words; legal 1..16 (AXI LEN 4 bits)
//  MASTER_ID  2   value driven on ARID_M/AWID_M, width `AXI_ID_BITS
// PORTS
//  clk                       in   1     clock; all logic on posedge
//  rst                       in   1     reset, asynchronous, active-low (0 = reset)
//  DMASRC / DMADST           in   32    source / destination byte address, word-aligned
//  DMALEN                    in   32    transfer length in 32-bit words
//  DMAEN                     in   1     enable level from config slave; start = high while IDLE
//  DMA_interrupt             out  1     completion interrupt, level
//  DMA_err                   out  1     bus-error flag (see CONFIGURATION)
//  ARID_M/AWID_M             out  `AXI_ID_BITS    = MASTER_ID
//  ARADDR_M/AWADDR_M         out  `AXI_ADDR_BITS  burst start address
//  ARLEN_M/AWLEN_M           out  `AXI_LEN_BITS   beats-1
//  ARSIZE_M/AWSIZE_M         out  `AXI_SIZE_BITS  fixed 3'b010
//  ARBURST_M/AWBURST_M       out  2               fixed 2'b01 (INCR)
//  ARVALID_M, AWVALID_M      out  1     address valid; ARREADY_M, AWREADY_M in 1 address ready
//  RID_M in `AXI_ID_BITS; RDATA_M in `AXI_DATA_BITS; RRESP_M in 2; RLAST_M, RVALID_M in 1; RREADY_M out 1
//  WDATA_M out `AXI_DATA_BITS; WSTRB_M out `AXI_STRB_BITS (fixed 4'hF); WLAST_M, WVALID_M out 1; WREADY_M in 1
//  BID_M in `AXI_ID_BITS; BRESP_M in 2; BVALID_M in 1; BREADY_M out 1
// BEHAVIOUR
//  Reset (rst=0): state IDLE; every output 0 except ARSIZE/AWSIZE=3'b010, ARBURST/AWBURST=2'b01,
//   WSTRB=4'hF, IDs=MASTER_ID; counters/buffer pointers 0. Reset mid-burst aborts immediately.
//  FSM IDLE->RADDR->RDATA->WADDR->WDATA->WRESP->(RADDR | DONE)->IDLE.
//  IDLE: DMAEN=1 latches src/dst/remaining=DMALEN; next RADDR, or DONE directly if DMALEN==0.
//  Burst size bl = min(remaining, MAX_BURST), recomputed on entry to RADDR. No 4KB splitting (SW aligns).
//  RADDR: ARVALID=1, ARADDR=src, ARLEN=bl-1; held stable until ARREADY; handshake cycle -> RDATA.
//  RDATA: RREADY=1; each R handshake writes RDATA into buffer[wptr++]; RLAST handshake -> WADDR,
//   src += bl*4. Early/late RLAST vs bl is not checked; transition follows RLAST only.
//  WADDR: AWVALID=1, AWADDR=dst, AWLEN=bl-1, held until AWREADY -> WDATA. AW strictly before W.
//  WDATA: WVALID=1, WDATA=buffer[rptr]; rptr++ per handshake; WLAST=1 on beat bl-1 -> WRESP.
//  WRESP: BREADY=1; B handshake: dst += bl*4, remaining -= bl; remaining==0 -> DONE else RADDR.
//  DONE: DMA_interrupt=1 (registered, asserts first DONE cycle); stays until DMAEN=0 -> IDLE,
//   interrupt cleared same edge. DMAEN drop during transfer ignored until DONE (no AXI abort).
//  Latency: one cycle per state visit minimum; zero-wait-slave burst of N words = 2N+5 cycles.
//  Address arithmetic 32-bit, wraps mod 2^32 silently. Buffer pointers reset to 0 per burst.
//  Valid signals never depend combinationally on ready inputs.
// CONFIGURATION
//  DMA_MASTER_ERR_EN defined: RRESP/BRESP != OKAY sets sticky DMA_err; after current burst completes
//   (RLAST/B handshake) go straight to DONE (skip remaining); DMA_err clears on DONE->IDLE.
//  Undefined: responses ignored, DMA_err tied 0.
// TESTING
//  DMALEN=4, SRC=0x0000_1000, DST=0x0002_0000, zero-wait slave -> 1 AR(LEN=3), 1 AW(LEN=3), data copied, IRQ.
//  DMALEN=40, MAX_BURST=16 -> bursts 16,16,8; ARADDR 0x1000,0x1040,0x1080; IRQ after 3rd B.
//  DMALEN=0, DMAEN=1 -> no AXI traffic, DMA_interrupt next cycle; DMAEN=0 -> IDLE, IRQ=0.
//  Random ARREADY/RVALID/AWREADY/WREADY/BVALID stalls -> ADDR/LEN/VALID/DATA stable while stalled, data intact.
//  rst=0 mid WDATA -> all valids 0 same cycle; after release DMAEN=1 restarts from DMASRC.
//  DMA_MASTER_ERR_EN, BRESP=2'b10 on burst 1 of 3 -> DMA_err=1, DONE, no 2nd AR issued.

Source files
------------

// File: rtl/dma_master_engine_if.sv
// dma_master_engine_if: AXI4 master bus bundle for the DMA data mover, with master and slave views.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

interface dma_master_engine_if;
  logic [`AXI_ID_BITS-1:0]   ARID_M;
  logic [`AXI_ADDR_BITS-1:0] ARADDR_M;
  logic [`AXI_LEN_BITS-1:0]  ARLEN_M;
  logic [`AXI_SIZE_BITS-1:0] ARSIZE_M;
  logic [1:0]                ARBURST_M;
  logic                      ARVALID_M;
  logic                      ARREADY_M;
  logic [`AXI_ID_BITS-1:0]   RID_M;
  logic [`AXI_DATA_BITS-1:0] RDATA_M;
  logic [1:0]                RRESP_M;
  logic                      RLAST_M;
  logic                      RVALID_M;
  logic                      RREADY_M;
  logic [`AXI_ID_BITS-1:0]   AWID_M;
  logic [`AXI_ADDR_BITS-1:0] AWADDR_M;
  logic [`AXI_LEN_BITS-1:0]  AWLEN_M;
  logic [`AXI_SIZE_BITS-1:0] AWSIZE_M;
  logic [1:0]                AWBURST_M;
  logic                      AWVALID_M;
  logic                      AWREADY_M;
  logic [`AXI_DATA_BITS-1:0] WDATA_M;
  logic [`AXI_STRB_BITS-1:0] WSTRB_M;
  logic                      WLAST_M;
  logic                      WVALID_M;
  logic                      WREADY_M;
  logic [`AXI_ID_BITS-1:0]   BID_M;
  logic [1:0]                BRESP_M;
  logic                      BVALID_M;
  logic                      BREADY_M;
  modport master (
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    input  ARREADY_M,
    input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    output RREADY_M,
    output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    input  AWREADY_M,
    output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
    input  WREADY_M,
    input  BID_M, BRESP_M, BVALID_M,
    output BREADY_M
  );
  modport slave (
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    output ARREADY_M,
    output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    input  RREADY_M,
    input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    output AWREADY_M,
    input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
    output WREADY_M,
    output BID_M, BRESP_M, BVALID_M,
    input  BREADY_M
  );
endinterface

// File: rtl/dma_master_engine.sv
// dma_master_engine: copies DMALEN words src->dst as INCR read bursts into a local buffer, then write bursts out.
// Define DMA_MASTER_ERR_EN to turn non-OKAY responses into a sticky DMA_err that ends the transfer early.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

module dma_master_engine #(
  parameter int                      MAX_BURST = 16,
  parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         DMASRC,
  input  logic [31:0]         DMADST,
  input  logic [31:0]         DMALEN,
  input  logic                DMAEN,
  output logic                DMA_interrupt,
  output logic                DMA_err,
  dma_master_engine_if.master bus
);
  localparam int LW = `AXI_LEN_BITS;
  localparam int PW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RADDR = 3'd1;
  localparam logic [2:0] S_RDATA = 3'd2;
  localparam logic [2:0] S_WADDR = 3'd3;
  localparam logic [2:0] S_WDATA = 3'd4;
  localparam logic [2:0] S_WRESP = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    r_state;
  logic [31:0]   r_src;
  logic [31:0]   r_dst;
  logic [31:0]   r_rem;
  logic [LW-1:0] r_len;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [31:0]   r_buf [MAX_BURST];
  logic [31:0]   w_bytes;
  logic [31:0]   w_rem_next;
  logic          w_r_hs;
  logic          w_wlast;
  logic          w_stop_r;
  logic          w_stop_b;
  logic          w_unused;

  // r_len holds beats-1 so ARLEN/AWLEN come straight from a register
  function automatic logic [LW-1:0] f_len(input logic [31:0] words);
    return (words == '0) ? '0 : (words >= 32'(MAX_BURST)) ? LW'(MAX_BURST - 1) : LW'(words - 32'd1);
  endfunction

  assign w_bytes    = (32'(r_len) + 32'd1) << 2;
  assign w_rem_next = r_rem - (32'(r_len) + 32'd1);
  assign w_r_hs     = (r_state == S_RDATA) && bus.RVALID_M;
  assign w_wlast    = (r_state == S_WDATA) && (LW'(r_rptr) == r_len);
  assign w_unused   = ^{bus.RID_M, bus.BID_M, bus.RRESP_M, bus.BRESP_M};

  assign bus.ARID_M        = MASTER_ID;
  assign bus.ARADDR_M      = r_src;
  assign bus.ARLEN_M       = r_len;
  assign bus.ARSIZE_M      = 3'b010;
  assign bus.ARBURST_M     = 2'b01;
  assign bus.ARVALID_M     = r_state == S_RADDR;
  assign bus.RREADY_M      = r_state == S_RDATA;
  assign bus.AWID_M        = MASTER_ID;
  assign bus.AWADDR_M      = r_dst;
  assign bus.AWLEN_M       = r_len;
  assign bus.AWSIZE_M      = 3'b010;
  assign bus.AWBURST_M     = 2'b01;
  assign bus.AWVALID_M     = r_state == S_WADDR;
  assign bus.WDATA_M       = (r_state == S_WDATA) ? r_buf[r_rptr] : '0;
  assign bus.WSTRB_M       = '1;
  assign bus.WLAST_M       = w_wlast;
  assign bus.WVALID_M      = r_state == S_WDATA;
  assign bus.BREADY_M      = r_state == S_WRESP;
  assign DMA_interrupt     = r_state == S_DONE;

`ifdef DMA_MASTER_ERR_EN
  logic r_err;
  logic w_rerr;
  logic w_berr;
  assign w_rerr   = w_r_hs && (bus.RRESP_M != 2'b00);
  assign w_berr   = (r_state == S_WRESP) && bus.BVALID_M && (bus.BRESP_M != 2'b00);
  assign w_stop_r = r_err || w_rerr;
  assign w_stop_b = r_err || w_berr;
  assign DMA_err  = r_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else if (r_state == S_DONE && !DMAEN) r_err <= 1'b0;
    else if (w_rerr || w_berr) r_err <= 1'b1;
  end
`else
  assign w_stop_r = 1'b0;
  assign w_stop_b = 1'b0;
  assign DMA_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_r_hs) r_buf[r_wptr] <= bus.RDATA_M;
  end

  // burst length is recomputed whenever RADDR is about to be entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_len   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (DMAEN) begin
          r_src   <= DMASRC;
          r_dst   <= DMADST;
          r_rem   <= DMALEN;
          r_len   <= f_len(DMALEN);
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_state <= (DMALEN == '0) ? S_DONE : S_RADDR;
        end
        S_RADDR: if (bus.ARREADY_M) r_state <= S_RDATA;
        S_RDATA: if (w_r_hs) begin
          r_wptr <= r_wptr + PW'(1);
          if (bus.RLAST_M) begin
            r_src   <= r_src + w_bytes;
            r_rptr  <= '0;
            r_state <= w_stop_r ? S_DONE : S_WADDR;
          end
        end
        S_WADDR: if (bus.AWREADY_M) r_state <= S_WDATA;
        S_WDATA: if (bus.WREADY_M) begin
          r_rptr <= r_rptr + PW'(1);
          if (w_wlast) r_state <= S_WRESP;
        end
        S_WRESP: if (bus.BVALID_M) begin
          r_dst   <= r_dst + w_bytes;
          r_rem   <= w_rem_next;
          r_len   <= f_len(w_rem_next);
          r_wptr  <= '0;
          r_state <= (w_rem_next == '0 || w_stop_b) ? S_DONE : S_RADDR;
        end
        S_DONE: if (!DMAEN) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
